// File: rtl/writeback_retire_unit.sv
// Multi-lane writeback/retire stage: retires up to LANES results per cycle in
// program order (lane 0 oldest) and drives the register-file write ports, a
// single CSR write port, the trap port and the instret counter.
//
// Handshake: upstream presents a group on memoryWritebackPayload; the group is
// accepted on a rising edge when any lane is valid and memoryWritebackReady is
// high. While ready is low, upstream holds the group stable and this unit
// finishes it across several cycles (one CSR write per cycle).

package writeback_retire_unit_pkg;

    typedef enum logic [1:0] {
        TRAP_NONE       = 2'd0,
        TRAP_ILLEGAL    = 2'd1,
        TRAP_MISALIGNED = 2'd2,
        TRAP_INTERRUPT  = 2'd3
    } trapType_;

    typedef logic [11:0] destinationCSR_;

    typedef struct packed {
        logic [31:0] pc;
        trapType_    trapType;
        logic [31:0] trapValue;
    } trapPayload_;

    typedef struct packed {
        logic           valid;
        logic [31:0]    pc;
        logic [4:0]     rd;
        logic           writebackEnable;
        logic [31:0]    data;
        logic           isCSR;
        logic           CSRWriteIntent;
        destinationCSR_ csrAddress;
        logic [31:0]    oldCSRValue;
        trapType_       trapType;
        logic [31:0]    trapValue;
    } memoryWritebackPayload_;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_SPLIT = 1'b1
    } retire_state_e;

endpackage

module writeback_retire_unit
    import writeback_retire_unit_pkg::*;
#(
    parameter int LANES         = 2,
    parameter int INSTRET_WIDTH = 64
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                interrupt,
    input  memoryWritebackPayload_ [LANES-1:0]  memoryWritebackPayload,
    output logic                                memoryWritebackReady,
    output logic [LANES-1:0]                    destinationEnable,
    output logic [LANES-1:0][4:0]               writeAddress,
    output logic [LANES-1:0][31:0]              writeData,
    output logic                                csrDestinationEnable,
    output destinationCSR_                      destinationCSR,
    output logic [31:0]                         csrWriteData,
    output logic                                trapValid,
    output trapPayload_                         trapData,
    output logic                                interruptTaken,
    output logic [$clog2(LANES+1)-1:0]          retireCount,
    output logic [INSTRET_WIDTH-1:0]            instret,
    output retire_state_e                       debug_state
);

    localparam int CNT_W = $clog2(LANES + 1);
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    retire_state_e            state_q, state_n;
    logic [IDX_W-1:0]         idx_q, idx_n;
    logic                     pending_q, pending_n;

    logic [LANES-1:0]         en_n;
    logic [LANES-1:0][4:0]    addr_n;
    logic [LANES-1:0][31:0]   data_n;
    logic                     csr_en_n;
    destinationCSR_           csr_addr_n;
    logic [31:0]              csr_data_n;
    logic                     trap_v_n;
    trapPayload_              trap_d_n;
    logic                     int_n;
    logic [CNT_W-1:0]         count_n;
    logic [INSTRET_WIDTH-1:0] instret_n;

    logic [LANES-1:0]         retire;
    logic [LANES-1:0]         wr;
    logic                     any_valid;
    logic                     lane0_exc;

    // Ready only in RUN; held low while reset is asserted.
    assign memoryWritebackReady = reset && (state_q == ST_RUN);
    assign debug_state          = state_q;

    // Scan the group (or the held remainder in SPLIT) and form next outputs.
    always_comb begin
        logic stop;
        logic seen_csr;
        logic split;
        logic csr_w;
        state_n    = state_q;
        idx_n      = idx_q;
        pending_n  = pending_q | interrupt;
        retire     = '0;
        wr         = '0;
        en_n       = '0;
        addr_n     = '0;
        data_n     = '0;
        csr_en_n   = 1'b0;
        csr_addr_n = '0;
        csr_data_n = '0;
        trap_v_n   = 1'b0;
        trap_d_n   = '0;
        int_n      = 1'b0;
        count_n    = '0;
        stop       = 1'b0;
        seen_csr   = 1'b0;
        split      = 1'b0;
        csr_w      = 1'b0;

        any_valid = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            any_valid = any_valid | memoryWritebackPayload[i].valid;
        end
        lane0_exc = memoryWritebackPayload[0].valid &&
                    (memoryWritebackPayload[0].trapType != TRAP_NONE);

        if (state_q == ST_RUN && any_valid && pending_q && !lane0_exc) begin
            // Interrupt squashes the whole accepted group; reported on lane 0.
            trap_v_n           = 1'b1;
            int_n              = 1'b1;
            trap_d_n.pc        = memoryWritebackPayload[0].pc;
            trap_d_n.trapType  = TRAP_INTERRUPT;
            trap_d_n.trapValue = memoryWritebackPayload[0].trapValue;
            pending_n          = interrupt;
        end else if (state_q == ST_SPLIT || any_valid) begin
            for (int i = 0; i < LANES; i++) begin
                csr_w = memoryWritebackPayload[i].isCSR &&
                        memoryWritebackPayload[i].CSRWriteIntent;
                if (i >= int'(state_q == ST_SPLIT ? idx_q : '0) && !stop &&
                    memoryWritebackPayload[i].valid) begin
                    if (memoryWritebackPayload[i].trapType != TRAP_NONE) begin
                        // Oldest trapping lane: it and all younger lanes are dropped.
                        trap_v_n           = 1'b1;
                        trap_d_n.pc        = memoryWritebackPayload[i].pc;
                        trap_d_n.trapType  = memoryWritebackPayload[i].trapType;
                        trap_d_n.trapValue = memoryWritebackPayload[i].trapValue;
                        stop               = 1'b1;
                    end else if (csr_w && seen_csr) begin
                        // Second CSR writer: defer it and everything younger.
                        split = 1'b1;
                        stop  = 1'b1;
                        idx_n = IDX_W'(i);
                    end else begin
                        retire[i] = 1'b1;
                        if (csr_w) begin
                            seen_csr   = 1'b1;
                            csr_en_n   = 1'b1;
                            csr_addr_n = memoryWritebackPayload[i].csrAddress;
                            csr_data_n = memoryWritebackPayload[i].data;
                        end
                    end
                end
            end
            if (split) begin
                state_n = ST_SPLIT;
            end else begin
                state_n = ST_RUN;
                idx_n   = '0;
            end
        end

        // Register-file writes: CSR lanes always write old value; rd 0 never.
        for (int i = 0; i < LANES; i++) begin
            wr[i] = retire[i] && memoryWritebackPayload[i].rd != 5'd0 &&
                    (memoryWritebackPayload[i].isCSR ||
                     memoryWritebackPayload[i].writebackEnable);
            if (retire[i]) begin
                count_n = count_n + CNT_W'(1);
            end
        end

        // Same-rd collisions inside one cycle: youngest writer wins.
        for (int i = 0; i < LANES; i++) begin
            en_n[i] = wr[i];
            for (int j = i + 1; j < LANES; j++) begin
                if (wr[j] && memoryWritebackPayload[j].rd == memoryWritebackPayload[i].rd) begin
                    en_n[i] = 1'b0;
                end
            end
            if (en_n[i]) begin
                addr_n[i] = memoryWritebackPayload[i].rd;
                data_n[i] = memoryWritebackPayload[i].isCSR ?
                            memoryWritebackPayload[i].oldCSRValue :
                            memoryWritebackPayload[i].data;
            end
        end

        instret_n = instret + INSTRET_WIDTH'(count_n);
    end

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q              <= ST_RUN;
            idx_q                <= '0;
            pending_q            <= 1'b0;
            destinationEnable    <= '0;
            writeAddress         <= '0;
            writeData            <= '0;
            csrDestinationEnable <= 1'b0;
            destinationCSR       <= '0;
            csrWriteData         <= '0;
            trapValid            <= 1'b0;
            trapData             <= '0;
            interruptTaken       <= 1'b0;
            retireCount          <= '0;
            instret              <= '0;
        end else begin
            state_q              <= state_n;
            idx_q                <= idx_n;
            pending_q            <= pending_n;
            destinationEnable    <= en_n;
            writeAddress         <= addr_n;
            writeData            <= data_n;
            csrDestinationEnable <= csr_en_n;
            destinationCSR       <= csr_addr_n;
            csrWriteData         <= csr_data_n;
            trapValid            <= trap_v_n;
            trapData             <= trap_d_n;
            interruptTaken       <= int_n;
            retireCount          <= count_n;
            instret              <= instret_n;
        end
    end

endmodule

// File: tb/tb_writeback_retire_unit.sv
// Directed bench for writeback_retire_unit (LANES=2, 4-bit instret so the
// counter wrap is reachable in a handful of cycles).
module tb_writeback_retire_unit;
    import writeback_retire_unit_pkg::*;

    localparam int LANES = 2;
    localparam int IW    = 4;

    logic                               clock = 1'b0;
    logic                               reset = 1'b0;
    logic                               interrupt = 1'b0;
    memoryWritebackPayload_ [LANES-1:0] pay = '0;
    logic                               memoryWritebackReady;
    logic [LANES-1:0]                   destinationEnable;
    logic [LANES-1:0][4:0]              writeAddress;
    logic [LANES-1:0][31:0]             writeData;
    logic                               csrDestinationEnable;
    destinationCSR_                     destinationCSR;
    logic [31:0]                        csrWriteData;
    logic                               trapValid;
    trapPayload_                        trapData;
    logic                               interruptTaken;
    logic [$clog2(LANES+1)-1:0]         retireCount;
    logic [IW-1:0]                      instret;
    retire_state_e                      debug_state;

    int n_cmp = 0;
    int n_err = 0;

    writeback_retire_unit #(.LANES(LANES), .INSTRET_WIDTH(IW)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .interrupt              (interrupt),
        .memoryWritebackPayload (pay),
        .memoryWritebackReady   (memoryWritebackReady),
        .destinationEnable      (destinationEnable),
        .writeAddress           (writeAddress),
        .writeData              (writeData),
        .csrDestinationEnable   (csrDestinationEnable),
        .destinationCSR         (destinationCSR),
        .csrWriteData           (csrWriteData),
        .trapValid              (trapValid),
        .trapData               (trapData),
        .interruptTaken         (interruptTaken),
        .retireCount            (retireCount),
        .instret                (instret),
        .debug_state            (debug_state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1ns after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic memoryWritebackPayload_ alu(input logic [4:0] rd, input logic [31:0] d,
                                                   input logic wbe);
        memoryWritebackPayload_ p;
        p                 = '0;
        p.valid           = 1'b1;
        p.pc              = 32'h1000 + {27'd0, rd};
        p.rd              = rd;
        p.writebackEnable = wbe;
        p.data            = d;
        return p;
    endfunction

    function automatic memoryWritebackPayload_ csr(input logic [4:0] rd, input logic [11:0] a,
                                                   input logic [31:0] d, input logic [31:0] old);
        memoryWritebackPayload_ p;
        p                = alu(rd, d, 1'b1);
        p.isCSR          = 1'b1;
        p.CSRWriteIntent = 1'b1;
        p.csrAddress     = a;
        p.oldCSRValue    = old;
        return p;
    endfunction

    initial begin
        // Reset state
        #2;
        chk("rst_en", destinationEnable, 0);
        chk("rst_ready", memoryWritebackReady, 0);
        chk("rst_instret", instret, 0);
        chk("rst_trap", trapValid, 0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("rel_ready", memoryWritebackReady, 1);
        chk("rel_state", debug_state, ST_RUN);

        // 1: two independent writes
        pay[0] = alu(5'd5, 32'hA, 1'b1);
        pay[1] = alu(5'd6, 32'hB, 1'b1);
        tick();
        chk("t1_en", destinationEnable, 2'b11);
        chk("t1_addr0", writeAddress[0], 5);
        chk("t1_addr1", writeAddress[1], 6);
        chk("t1_data0", writeData[0], 32'hA);
        chk("t1_data1", writeData[1], 32'hB);
        chk("t1_cnt", retireCount, 2);
        chk("t1_instret", instret, 2);
        pay = '0;
        tick();
        chk("idle_en", destinationEnable, 0);
        chk("idle_cnt", retireCount, 0);
        chk("idle_instret", instret, 2);

        // 2: WAW on rd 7, then rd 0 and a non-writing lane
        pay[0] = alu(5'd7, 32'h11, 1'b1);
        pay[1] = alu(5'd7, 32'h22, 1'b1);
        tick();
        chk("t2_en", destinationEnable, 2'b10);
        chk("t2_data1", writeData[1], 32'h22);
        chk("t2_instret", instret, 4);
        pay[0] = alu(5'd0, 32'h33, 1'b1);
        pay[1] = alu(5'd9, 32'h44, 1'b0);
        tick();
        chk("t2b_en", destinationEnable, 2'b00);
        chk("t2b_cnt", retireCount, 2);
        chk("t2b_instret", instret, 6);

        // 3: lane 1 illegal instruction
        pay[0] = alu(5'd3, 32'h33, 1'b1);
        pay[1] = alu(5'd4, 32'h55, 1'b1);
        pay[1].pc = 32'h100;
        pay[1].trapType = TRAP_ILLEGAL;
        pay[1].trapValue = 32'hDEAD;
        tick();
        chk("t3_en", destinationEnable, 2'b01);
        chk("t3_trap", trapValid, 1);
        chk("t3_pc", trapData.pc, 32'h100);
        chk("t3_type", trapData.trapType, TRAP_ILLEGAL);
        chk("t3_tval", trapData.trapValue, 32'hDEAD);
        chk("t3_instret", instret, 7);
        pay = '0;
        tick();
        chk("t3_trap_pulse", trapValid, 0);

        // 4: two CSR writers split across two cycles
        pay[0] = csr(5'd4, 12'h300, 32'h1111, 32'hAAAA);
        pay[1] = csr(5'd8, 12'h305, 32'h2222, 32'hBBBB);
        tick();
        chk("t4a_csren", csrDestinationEnable, 1);
        chk("t4a_csr", destinationCSR, 12'h300);
        chk("t4a_csrdata", csrWriteData, 32'h1111);
        chk("t4a_en", destinationEnable, 2'b01);
        chk("t4a_data0", writeData[0], 32'hAAAA);
        chk("t4a_ready", memoryWritebackReady, 0);
        chk("t4a_state", debug_state, ST_SPLIT);
        chk("t4a_instret", instret, 8);
        tick();
        chk("t4b_csren", csrDestinationEnable, 1);
        chk("t4b_csr", destinationCSR, 12'h305);
        chk("t4b_csrdata", csrWriteData, 32'h2222);
        chk("t4b_en", destinationEnable, 2'b10);
        chk("t4b_data1", writeData[1], 32'hBBBB);
        chk("t4b_ready", memoryWritebackReady, 1);
        chk("t4b_instret", instret, 9);
        pay = '0;
        tick();
        chk("t4c_csren", csrDestinationEnable, 0);
        chk("t4c_instret", instret, 9);

        // 5: interrupt pulse then a group
        interrupt = 1'b1;
        tick();
        interrupt = 1'b0;
        chk("t5_no_early_trap", trapValid, 0);
        pay[0] = alu(5'd10, 32'h66, 1'b1);
        pay[1] = alu(5'd11, 32'h77, 1'b1);
        tick();
        chk("t5_en", destinationEnable, 0);
        chk("t5_trap", trapValid, 1);
        chk("t5_int", interruptTaken, 1);
        chk("t5_type", trapData.trapType, TRAP_INTERRUPT);
        chk("t5_pc", trapData.pc, 32'h100A);
        chk("t5_instret", instret, 9);
        pay = '0;
        tick();
        chk("t5_int_pulse", interruptTaken, 0);

        // 5b: lane 0 exception beats the interrupt, which stays pending
        interrupt = 1'b1;
        tick();
        interrupt = 1'b0;
        pay[0] = alu(5'd12, 32'h88, 1'b1);
        pay[0].trapType = TRAP_MISALIGNED;
        tick();
        chk("t5b_trap", trapValid, 1);
        chk("t5b_int", interruptTaken, 0);
        chk("t5b_type", trapData.trapType, TRAP_MISALIGNED);
        pay[0] = alu(5'd13, 32'h99, 1'b1);
        tick();
        chk("t5c_int", interruptTaken, 1);
        chk("t5c_en", destinationEnable, 0);
        chk("t5c_instret", instret, 9);

        // 6: bring instret to 15, then wrap to 1
        pay[0] = alu(5'd1, 32'h1, 1'b1);
        pay[1] = alu(5'd2, 32'h2, 1'b1);
        tick();
        tick();
        tick();
        chk("t6_instret_max", instret, 15);
        tick();
        chk("t6_wrap", instret, 1);

        // 6b: reset while in SPLIT
        pay[0] = csr(5'd4, 12'h340, 32'h1, 32'h2);
        pay[1] = csr(5'd5, 12'h341, 32'h3, 32'h4);
        tick();
        chk("t6b_state", debug_state, ST_SPLIT);
        reset = 1'b0;
        #1;
        chk("t6b_rst_state", debug_state, ST_RUN);
        chk("t6b_rst_en", destinationEnable, 0);
        chk("t6b_rst_csren", csrDestinationEnable, 0);
        chk("t6b_rst_instret", instret, 0);
        chk("t6b_rst_cnt", retireCount, 0);
        chk("t6b_rst_ready", memoryWritebackReady, 0);
        pay = '0;
        tick();
        reset = 1'b1;
        tick();
        chk("t6b_ready", memoryWritebackReady, 1);
        chk("t6b_csren_after", csrDestinationEnable, 0);
        chk("t6b_instret_after", instret, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
